enc16to4_low_scan: RTL
======================

// Module: enc16to4_low_scan
// PURPOSE
//  Sequential 16-to-4 encoder, the inverse of the active-low 4-to-16 decoder tree.
//  - Captures a snapshot of 16 active-low request lines.
//  - Emits the 4-bit index of every asserted line, one code per valid/ready handshake.
//  - Order is lowest index first.
//  - Sits between decoded select/interrupt lines and a consumer needing binary codes.
// PARAMETERS
//  N   16  number of active-low request lines (must be a power of 2)
//  W   4   code width, equal to $clog2(N)
// PORTS
//  clk     in   1   rising-edge clock
//  rst_n   in   1   asynchronous active-low reset
//  e       in   1   enable, active-high; low aborts any scan
//  y_n     in   N   request lines, active-low (0 = asserted)
//  load    in   1   capture y_n when idle
//  ready   in   1   consumer accepts code this cycle
//  code    out  W   index of current pending request (registered)
//  valid   out  1   code is meaningful
//  busy    out  1   scan in progress
//  none    out  1   one-cycle pulse: load captured no asserted lines
//  done    out  1   one-cycle pulse: last code of a snapshot accepted
//  count   out  W+1 number of asserted lines in the last capture (0..N)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - code=0, valid=0, busy=0, none=0, done=0, count=0.
//  - pending=0, state=IDLE.
//  FSM states: IDLE, SCAN.
//  IDLE, on e=1 & load=1 at edge N:
//  - pending <= ~y_n; count <= popcount(~y_n).
//  - If ~y_n == 0: none=1 in cycle N+1; stay IDLE; valid stays 0.
//  - Else: state <= SCAN; busy=1, valid=1, code=lowest set index, all from cycle N+1.
//    Load-to-first-code latency is 1 clock.
//  IDLE, any other input: hold; outputs other than count are 0.
//  SCAN, handshake:
//  - Transfer occurs on an edge where valid & ready.
//  - At a transfer, the bit at index code is cleared.
//  - If other bits remain: code updates to the next lowest set index the following
//    cycle; valid stays 1. Throughput is 1 code/cycle with ready held high.
//  - If it was the last bit: valid=0, busy=0, done=1 for one cycle; state <= IDLE.
//  - valid & ~ready: code, valid and pending hold stable (no change until accepted).
//  SCAN, other inputs:
//  - load=1: ignored; y_n changes are ignored during the scan.
//  - e=0 at any edge: abort. Next cycle pending=0, valid=0, busy=0, state=IDLE;
//    done is NOT pulsed. Abort takes priority over a simultaneous transfer.
//  Completion with new work:
//  - done and a new load in the same cycle: the load is accepted. FSM is IDLE, so
//    that edge captures, and the next snapshot's code appears one cycle after done.
//  Priority rule: bit 0 is highest; code = min{i : pending[i]=1}.
//  Width rules:
//  - count is W+1 bits so that all-asserted (y_n=16'h0000) gives 16.
//  - code never exceeds N-1.
//  Reset mid-scan: all state clears immediately; no done or none pulse.
// STRUCTURE
//  Shared package enc_pkg:
//  - enc_state_t enum {IDLE, SCAN}.
//  - ENC_N=16, ENC_W=4 constants, reused by the decoder family.
//  Sub-module lsb_find #(N,W):
//  - Combinational lowest-set-bit finder; pending -> {idx[W-1:0], any}.
//  - Instantiated once for the next code. Popcount is inline.
//  Top module holds the FSM, the pending register and the output registers.
// TESTING
//  1 reset:
//    rst_n=0 mid-scan with y_n=16'h00FF
//    -> same cycle: valid=0, busy=0, code=0, count=0; no done.
//  2 single request:
//    y_n=16'hFFF7, load=1, ready=1
//    -> cycle+1: code=3, valid=1, count=1; cycle+2: done=1, valid=0.
//  3 multiple with backpressure:
//    y_n=16'h7FFA (lines 0,2,15), ready pulsed every 3rd cycle
//    -> codes 0, 2, 15 in order; each held stable while ready=0; count=3.
//  4 no requests:
//    y_n=16'hFFFF, load=1
//    -> none=1 for 1 cycle; valid never rises; count=0.
//  5 all asserted:
//    y_n=16'h0000, ready=1
//    -> codes 0..15 on consecutive cycles; count=16; done after code 15.
//  6 abort and reload:
//    e=0 after 2 codes of 16'h0F0F
//    -> IDLE next cycle, no done.
//    Then load while done=1 high -> first new code exactly 1 cycle later.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants and state type for the 16-line encoder/decoder family.
// Exports ENC_N, ENC_W and the enc_state_t scan FSM encoding.
package enc_pkg;

    localparam int ENC_N = 16;
    localparam int ENC_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } enc_state_t;

endpackage

// File: rtl/enc16to4_low_scan_lsb_find.sv
// Combinational lowest-set-bit finder.
// Ports: req_i (N request bits) -> idx_o (lowest set index), any_o (any set).
module lsb_find
    import enc_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int W = ENC_W
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/enc16to4_low_scan.sv
// Sequential 16-to-4 encoder: snapshots active-low requests, then emits the
// index of each asserted line lowest-first over a valid/ready handshake.
// Ports: clk, rst_n, e, y_n, load, ready in; code, valid, busy, none, done,
// count out (all outputs registered).
module enc16to4_low_scan
    import enc_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int W = ENC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         e,
    input  logic [N-1:0] y_n,
    input  logic         load,
    input  logic         ready,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         busy,
    output logic         none,
    output logic         done,
    output logic [W:0]   count
);

    enc_state_t   state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] code_q, code_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         none_q, none_d;
    logic         done_q, done_d;
    logic [W:0]   count_q, count_d;

    logic [N-1:0] req;
    logic [N-1:0] served;
    logic [N-1:0] remain;
    logic [W:0]   pop;
    logic [W-1:0] nxt_idx;
    logic         nxt_any;

    assign req    = ~y_n;
    assign served = {{(N-1){1'b0}}, 1'b1} << code_q;
    assign remain = pending_q & ~served;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + {{W{1'b0}}, req[i]};
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        none_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                pending_d = '0;
                if (e && load) begin
                    pending_d = req;
                    count_d   = pop;
                    if (req == '0) begin
                        none_d = 1'b1;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                // Abort wins over a transfer on the same edge.
                if (!e) begin
                    pending_d = '0;
                    state_d   = IDLE;
                end else if (valid_q && ready) begin
                    pending_d = remain;
                    if (remain == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    // Next code comes straight from the next pending set, so a held
    // transfer reproduces the current code unchanged.
    lsb_find #(
        .N(N),
        .W(W)
    ) u_lsb (
        .req_i(pending_d),
        .idx_o(nxt_idx),
        .any_o(nxt_any)
    );

    assign valid_d = (state_d == SCAN) && nxt_any;
    assign busy_d  = valid_d;
    assign code_d  = valid_d ? nxt_idx : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            none_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            none_q    <= none_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign none  = none_q;
    assign done  = done_q;
    assign count = count_q;

endmodule
